// File: rtl/controlador_banco_registradores.sv
// Initiator-side controller for the 32x16 register file. It serialises operand
// reads and buffered result writes onto the file's single RW port. Writes that
// target a pending read's operands are drained first. Out-of-range addresses
// are flagged.
module controlador_banco_registradores #(
  parameter int PROFUNDIDADE = 2,
  parameter int LARGURA_DADO = 16,
  parameter int LARGURA_END  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_leitura,
  input  logic [LARGURA_END-1:0]  end_A,
  input  logic [LARGURA_END-1:0]  end_B,
  output logic                    pronto_leitura,
  output logic [LARGURA_DADO-1:0] dado_A,
  output logic [LARGURA_DADO-1:0] dado_B,
  output logic                    leitura_valida,
  input  logic                    req_escrita,
  input  logic [LARGURA_END-1:0]  end_C,
  input  logic [LARGURA_DADO-1:0] dado_escrita,
  output logic                    escrita_cheia,
  output logic                    buffer_vazio,
  output logic                    erro_endereco,
  output logic [LARGURA_END-1:0]  regA,
  output logic [LARGURA_END-1:0]  regB,
  output logic [LARGURA_END-1:0]  regC,
  output logic [LARGURA_DADO-1:0] dado,
  output logic                    RW,
  input  logic [LARGURA_DADO-1:0] regsaidaA,
  input  logic [LARGURA_DADO-1:0] regsaidaB
);

  localparam int                     PW         = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [PW:0]            CONT_CHEIO = (PW+1)'(PROFUNDIDADE);
  localparam logic [PW:0]            UM_CONT    = (PW+1)'(1);
  localparam logic [PW-1:0]          UM_PTR     = PW'(1);
  localparam logic [LARGURA_END-1:0] END_MAX    = LARGURA_END'(31);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] LEITURA = 2'd1;
  localparam logic [1:0] CAPTURA = 2'd2;

  // read-side state
  logic [1:0]              estado_r, estado_prox_s;
  logic                    pendente_r;
  logic [LARGURA_END-1:0]  end_a_r, end_b_r;
  logic                    inval_a_r, inval_b_r;
  logic [LARGURA_DADO-1:0] dado_a_r, dado_b_r;
  logic                    leitura_valida_r, erro_r;

  // write buffer
  logic [LARGURA_END-1:0]  fifo_end_r  [PROFUNDIDADE];
  logic [LARGURA_DADO-1:0] fifo_dado_r [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0] val_r;
  logic [PW-1:0]           ptr_esc_r, ptr_lei_r;
  logic [PW:0]             cont_r, cont_prox_s;
  logic                    escrita_cheia_r, buffer_vazio_r;

  // register-file bus
  logic [LARGURA_END-1:0]  reg_a_r, reg_b_r, reg_c_r;
  logic [LARGURA_DADO-1:0] dado_r;
  logic                    rw_r;

  logic end_a_fora_s, end_b_fora_s, end_c_fora_s;
  logic aceita_leitura_s, tenta_escrita_s, push_s, pop_s;
  logic hazard_s, emite_leitura_s;

  assign end_a_fora_s     = (end_A > END_MAX);
  assign end_b_fora_s     = (end_B > END_MAX);
  assign end_c_fora_s     = (end_C > END_MAX);
  assign aceita_leitura_s = req_leitura & ~pendente_r;
  assign tenta_escrita_s  = req_escrita & ~escrita_cheia_r;
  assign push_s           = tenta_escrita_s & ~end_c_fora_s;
  assign emite_leitura_s  = pendente_r & (estado_r == OCIOSO) & ~hazard_s;
  assign pop_s            = ~emite_leitura_s & ~buffer_vazio_r;

  // Hazard: a buffered write targets a valid operand of the pending read
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      if (val_r[i] && ((!inval_a_r && (fifo_end_r[i] == end_a_r)) ||
                       (!inval_b_r && (fifo_end_r[i] == end_b_r)))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Next buffer occupancy from this cycle's push/pop
  always_comb begin
    cont_prox_s = cont_r;
    case ({push_s, pop_s})
      2'b10:   cont_prox_s = cont_r + UM_CONT;
      2'b01:   cont_prox_s = cont_r - UM_CONT;
      default: cont_prox_s = cont_r;
    endcase
  end

  // Read sequencer next state: idle until issued, then one bus cycle and one capture cycle
  always_comb begin
    estado_prox_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (emite_leitura_s) begin
          estado_prox_s = LEITURA;
        end else begin
          estado_prox_s = OCIOSO;
        end
      end
      LEITURA: estado_prox_s = CAPTURA;
      CAPTURA: estado_prox_s = OCIOSO;
      default: estado_prox_s = OCIOSO;
    endcase
  end

  // Write buffer storage, pointers and registered full/empty flags
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_esc_r       <= '0;
      ptr_lei_r       <= '0;
      cont_r          <= '0;
      val_r           <= '0;
      escrita_cheia_r <= 1'b0;
      buffer_vazio_r  <= 1'b1;
    end else begin
      if (pop_s) begin
        val_r[ptr_lei_r] <= 1'b0;
        ptr_lei_r        <= ptr_lei_r + UM_PTR;
      end
      if (push_s) begin
        val_r[ptr_esc_r]       <= 1'b1;
        fifo_end_r[ptr_esc_r]  <= end_C;
        fifo_dado_r[ptr_esc_r] <= dado_escrita;
        ptr_esc_r              <= ptr_esc_r + UM_PTR;
      end
      cont_r          <= cont_prox_s;
      escrita_cheia_r <= (cont_prox_s == CONT_CHEIO);
      buffer_vazio_r  <= (cont_prox_s == '0);
    end
  end

  // Read acceptance, operand capture, valid pulse and address-error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r         <= OCIOSO;
      pendente_r       <= 1'b0;
      end_a_r          <= '0;
      end_b_r          <= '0;
      inval_a_r        <= 1'b0;
      inval_b_r        <= 1'b0;
      dado_a_r         <= '0;
      dado_b_r         <= '0;
      leitura_valida_r <= 1'b0;
      erro_r           <= 1'b0;
    end else begin
      estado_r <= estado_prox_s;
      if (aceita_leitura_s) begin
        pendente_r <= 1'b1;
        end_a_r    <= end_a_fora_s ? '0 : end_A;
        end_b_r    <= end_b_fora_s ? '0 : end_B;
        inval_a_r  <= end_a_fora_s;
        inval_b_r  <= end_b_fora_s;
      end else if (estado_r == CAPTURA) begin
        pendente_r <= 1'b0;
      end
      if (estado_r == CAPTURA) begin
        dado_a_r <= inval_a_r ? '0 : regsaidaA;
        dado_b_r <= inval_b_r ? '0 : regsaidaB;
      end
      leitura_valida_r <= (estado_r == CAPTURA);
      erro_r <= (aceita_leitura_s & (end_a_fora_s | end_b_fora_s)) |
                (tenta_escrita_s & end_c_fora_s);
    end
  end

  // Bus arbitration: unblocked read first, else drain one buffered write, else idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_r    <= 1'b0;
      reg_a_r <= '0;
      reg_b_r <= '0;
      reg_c_r <= '0;
      dado_r  <= '0;
    end else if (emite_leitura_s) begin
      rw_r    <= 1'b0;
      reg_a_r <= end_a_r;
      reg_b_r <= end_b_r;
    end else if (pop_s) begin
      rw_r    <= 1'b1;
      reg_c_r <= fifo_end_r[ptr_lei_r];
      dado_r  <= fifo_dado_r[ptr_lei_r];
    end else begin
      rw_r <= 1'b0;
    end
  end

  assign pronto_leitura = ~pendente_r;
  assign dado_A         = dado_a_r;
  assign dado_B         = dado_b_r;
  assign leitura_valida = leitura_valida_r;
  assign escrita_cheia  = escrita_cheia_r;
  assign buffer_vazio   = buffer_vazio_r;
  assign erro_endereco  = erro_r;
  assign regA           = reg_a_r;
  assign regB           = reg_b_r;
  assign regC           = reg_c_r;
  assign dado           = dado_r;
  assign RW             = rw_r;

endmodule

// File: tb/tb_controlador_banco_registradores.sv
// Self-checking bench for controlador_banco_registradores: directed scenarios
// followed by randomized traffic checked against a register-level reference.
`timescale 1ns/1ps
module tb_controlador_banco_registradores;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_leitura, req_escrita;
  logic [5:0]  end_A, end_B, end_C;
  logic [15:0] dado_escrita;
  logic        pronto_leitura, leitura_valida, escrita_cheia, buffer_vazio, erro_endereco;
  logic [15:0] dado_A, dado_B, dado;
  logic [5:0]  regA, regB, regC;
  logic        RW;
  logic [15:0] regsaidaA = 16'h0000;
  logic [15:0] regsaidaB = 16'h0000;

  controlador_banco_registradores #(.PROFUNDIDADE(P), .LARGURA_DADO(16), .LARGURA_END(6)) dut (
    .clk(clk), .reset(reset),
    .req_leitura(req_leitura), .end_A(end_A), .end_B(end_B),
    .pronto_leitura(pronto_leitura), .dado_A(dado_A), .dado_B(dado_B),
    .leitura_valida(leitura_valida),
    .req_escrita(req_escrita), .end_C(end_C), .dado_escrita(dado_escrita),
    .escrita_cheia(escrita_cheia), .buffer_vazio(buffer_vazio), .erro_endereco(erro_endereco),
    .regA(regA), .regB(regB), .regC(regC), .dado(dado), .RW(RW),
    .regsaidaA(regsaidaA), .regsaidaB(regsaidaB)
  );

  always #5 clk = ~clk;

  // Register file: writes on RW=1, synchronous read of regA/regB on RW=0
  logic [15:0] rf [32] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (RW) rf[regC[4:0]] <= dado;
    else begin
      regsaidaA <= rf[regA[4:0]];
      regsaidaB <= rf[regB[4:0]];
    end
  end

  // Bus write monitor, sampled away from the active edge
  int         n_rw = 0;
  logic [5:0] commits [$];
  always @(negedge clk) begin
    if (RW) begin
      n_rw <= n_rw + 1;
      commits.push_back(regC);
    end
  end

  logic [15:0] ref_mem [32];
  int          n_aval = 0;
  int          n_falhas = 0;
  logic        hist_rw   [0:31];
  logic [5:0]  hist_rega [0:31];
  logic [5:0]  hist_regb [0:31];
  logic [5:0]  hist_regc [0:31];

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_aval++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic registra(input int i);
    hist_rw[i]   = RW;
    hist_rega[i] = regA;
    hist_regb[i] = regB;
    hist_regc[i] = regC;
  endtask

  task automatic confere_reset(input string tag);
    verifica({tag, "_RW"}, RW, 1'b0);
    verifica({tag, "_regA"}, regA, 6'd0);
    verifica({tag, "_regB"}, regB, 6'd0);
    verifica({tag, "_regC"}, regC, 6'd0);
    verifica({tag, "_dado"}, dado, 16'h0);
    verifica({tag, "_dadoA"}, dado_A, 16'h0);
    verifica({tag, "_dadoB"}, dado_B, 16'h0);
    verifica({tag, "_valida"}, leitura_valida, 1'b0);
    verifica({tag, "_pronto"}, pronto_leitura, 1'b1);
    verifica({tag, "_cheia"}, escrita_cheia, 1'b0);
    verifica({tag, "_vazio"}, buffer_vazio, 1'b1);
    verifica({tag, "_erro"}, erro_endereco, 1'b0);
  endtask

  // Issue one read (optionally with a write on the same edge); idx counts cycles
  // from acceptance: idx=1 is the cycle right after the accepting edge
  task automatic ler(input logic [5:0] a, input logic [5:0] b, input logic wr,
                     input logic [5:0] c, input logic [15:0] d,
                     output int idx, output logic erro1);
    int t = 0;
    while (!pronto_leitura && t < 20) begin ciclo(); t++; end
    req_leitura = 1'b1; end_A = a; end_B = b;
    req_escrita = wr; end_C = c; dado_escrita = d;
    ciclo();
    req_leitura = 1'b0; req_escrita = 1'b0;
    erro1 = erro_endereco;
    idx = 1;
    registra(idx);
    while (!leitura_valida && idx < 20) begin
      ciclo(); idx++; registra(idx);
    end
  endtask

  int          idx, n0, c0, lv, t;
  logic        e1;
  logic        pend, exp_erro, rd, wr;
  logic [5:0]  pa, pb, a, b, c;
  logic [15:0] ea, eb, d;
  int          plat;

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;
    reset = 1'b1; req_leitura = 1'b0; req_escrita = 1'b0;
    end_A = 6'd0; end_B = 6'd0; end_C = 6'd0; dado_escrita = 16'h0;
    ciclo(); ciclo();
    confere_reset("reset_ini");
    reset = 1'b0;
    ciclo();

    // basic write then read
    n0 = n_rw;
    req_escrita = 1'b1; end_C = 6'd0; dado_escrita = 16'h0000; ciclo(); ref_mem[0] = 16'h0000;
    end_C = 6'd5; dado_escrita = 16'h1234; ciclo(); ref_mem[5] = 16'h1234;
    req_escrita = 1'b0;
    repeat (3) ciclo();
    ler(6'd5, 6'd0, 1'b0, 6'd0, 16'h0, idx, e1);
    verifica("t1_lat", idx, 4);
    verifica("t1_dadoA", dado_A, 16'h1234);
    verifica("t1_dadoB", dado_B, 16'h0000);
    verifica("t1_erro", e1, 1'b0);
    verifica("t1_pronto_valida", pronto_leitura, 1'b1);
    verifica("t1_n_rw", n_rw - n0, 2);

    // write and read of the same register on the same edge
    ref_mem[7] = 16'hBEEF;
    ler(6'd7, 6'd0, 1'b1, 6'd7, 16'hBEEF, idx, e1);
    verifica("t2_lat", idx, 5);
    verifica("t2_rw_n2", hist_rw[2], 1'b1);
    verifica("t2_regC_n2", hist_regc[2], 6'd7);
    verifica("t2_rw_n3", hist_rw[3], 1'b0);
    verifica("t2_regA_n3", hist_rega[3], 6'd7);
    verifica("t2_dadoA", dado_A, 16'hBEEF);
    verifica("t2_dadoB", dado_B, 16'h0000);

    // full buffer drops a write
    c0 = commits.size();
    req_leitura = 1'b1; end_A = 6'd1; end_B = 6'd1;
    req_escrita = 1'b1; end_C = 6'd2; dado_escrita = 16'h2222;
    ciclo(); ref_mem[2] = 16'h2222;
    req_leitura = 1'b0;
    verifica("t3_cheia_n1", escrita_cheia, 1'b0);
    end_C = 6'd3; dado_escrita = 16'h3333;
    ciclo(); ref_mem[3] = 16'h3333;
    verifica("t3_cheia_n2", escrita_cheia, 1'b1);
    end_C = 6'd4; dado_escrita = 16'h4444;
    ciclo();
    req_escrita = 1'b0;
    t = 0;
    while (!leitura_valida && t < 20) begin ciclo(); t++; end
    verifica("t3_valida", leitura_valida, 1'b1);
    verifica("t3_dadoA", dado_A, ref_mem[1]);
    repeat (4) ciclo();
    verifica("t3_n_commits", commits.size() - c0, 2);
    if (commits.size() >= c0 + 2) begin
      verifica("t3_ordem0", commits[c0], 6'd2);
      verifica("t3_ordem1", commits[c0+1], 6'd3);
    end

    // out-of-range write and read
    req_escrita = 1'b1; end_C = 6'd40; dado_escrita = 16'h5555;
    ciclo();
    req_escrita = 1'b0;
    verifica("t4_erro_esc", erro_endereco, 1'b1);
    n0 = n_rw;
    ciclo();
    verifica("t4_erro_pulso", erro_endereco, 1'b0);
    verifica("t4_vazio", buffer_vazio, 1'b1);
    repeat (3) ciclo();
    verifica("t4_sem_rw", n_rw - n0, 0);
    ler(6'd33, 6'd5, 1'b0, 6'd0, 16'h0, idx, e1);
    verifica("t4_erro_lei", e1, 1'b1);
    verifica("t4_lat", idx, 4);
    verifica("t4_regA_bus", hist_rega[2], 6'd0);
    verifica("t4_regB_bus", hist_regb[2], 6'd5);
    verifica("t4_dadoA", dado_A, 16'h0000);
    verifica("t4_dadoB", dado_B, 16'h1234);

    // reset while a read and a write are in flight
    req_leitura = 1'b1; end_A = 6'd5; end_B = 6'd5;
    ciclo();
    req_leitura = 1'b0;
    ciclo();
    req_escrita = 1'b1; end_C = 6'd11; dado_escrita = 16'hAAAA;
    ciclo();
    req_escrita = 1'b0;
    verifica("t5_vazio_antes", buffer_vazio, 1'b0);
    reset = 1'b1;
    ciclo();
    confere_reset("t5_reset");
    reset = 1'b0;
    n0 = n_rw; lv = 0;
    repeat (6) begin
      ciclo();
      if (leitura_valida) lv++;
    end
    verifica("t5_sem_valida", lv, 0);
    verifica("t5_sem_rw", n_rw - n0, 0);

    // back-to-back reads, request held while busy
    req_leitura = 1'b1; end_A = 6'd5; end_B = 6'd0;
    ciclo();
    end_A = 6'd7; end_B = 6'd7;
    idx = 1;
    while (!leitura_valida && idx < 20) begin ciclo(); idx++; end
    verifica("t6_lat1", idx, 4);
    verifica("t6_dadoA1", dado_A, 16'h1234);
    verifica("t6_pronto", pronto_leitura, 1'b1);
    ciclo();
    req_leitura = 1'b0;
    verifica("t6_aceita", pronto_leitura, 1'b0);
    idx = 1;
    while (!leitura_valida && idx < 20) begin ciclo(); idx++; end
    verifica("t6_lat2", idx, 4);
    verifica("t6_dadoA2", dado_A, 16'hBEEF);
    verifica("t6_dadoB2", dado_B, 16'hBEEF);
    ciclo();

    // randomized traffic against the register-level reference
    pend = 1'b0; exp_erro = 1'b0; plat = 0;
    pa = 6'd0; pb = 6'd0; ea = 16'h0; eb = 16'h0;
    for (int k = 0; k < 400; k++) begin
      verifica("aleat_erro", erro_endereco, exp_erro);
      if (pend) plat++;
      if (leitura_valida) begin
        if (pend) begin
          verifica("aleat_dadoA", dado_A, ea);
          verifica("aleat_dadoB", dado_B, eb);
          verifica("aleat_lat", (plat >= 4) && (plat <= 4 + P), 1'b1);
          pend = 1'b0;
        end else begin
          verifica("aleat_valida_espuria", leitura_valida, 1'b0);
        end
      end else if (pend && plat > 4 + P) begin
        verifica("aleat_timeout", leitura_valida, 1'b1);
        pend = 1'b0;
      end
      verifica("aleat_pronto", pronto_leitura, !pend);

      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 1) == 1);
      a  = 6'($urandom_range(0, 39));
      b  = 6'($urandom_range(0, 39));
      c  = 6'($urandom_range(0, 39));
      d  = 16'($urandom);
      if (pend) begin
        while (c == pa || c == pb) c = 6'($urandom_range(0, 39));
      end
      exp_erro = (rd && pronto_leitura && (a > 6'd31 || b > 6'd31)) ||
                 (wr && !escrita_cheia && c > 6'd31);
      if (wr && !escrita_cheia && c <= 6'd31) ref_mem[c[4:0]] = d;
      if (rd && pronto_leitura) begin
        pend = 1'b1; plat = 0; pa = a; pb = b;
        ea = (a > 6'd31) ? 16'h0 : ref_mem[a[4:0]];
        eb = (b > 6'd31) ? 16'h0 : ref_mem[b[4:0]];
      end
      req_leitura = rd; end_A = a; end_B = b;
      req_escrita = wr; end_C = c; dado_escrita = d;
      ciclo();
    end
    req_leitura = 1'b0; req_escrita = 1'b0;
    repeat (12) ciclo();
    verifica("final_vazio", buffer_vazio, 1'b1);
    for (int i = 0; i < 32; i++) verifica($sformatf("mem_R%0d", i), rf[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
    $finish;
  end

endmodule
